// File: rtl/sequencer_control_unit_if.sv
// Control/status bundle between the sequencer and the ALU-system datapath.
// master: sequencer side (reads IROut/ALUOutFlag, drives every control input).
// slave : datapath side (drives IROut/ALUOutFlag, consumes the controls).
interface sequencer_control_unit_if;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [2:0]  RF_OutASel;
   logic [2:0]  RF_OutBSel;
   logic [2:0]  RF_FunSel;
   logic [3:0]  RF_RegSel;
   logic [3:0]  RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic [1:0]  ARF_OutCSel;
   logic [1:0]  ARF_OutDSel;
   logic [2:0]  ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH;
   logic        IR_Write;
   logic        Mem_CS;
   logic        Mem_WR;
   logic        ALU_WF;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic        MuxCSel;
   logic        Halted;

   modport master (
      input  IROut, ALUOutFlag,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
             ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Write, Mem_CS, Mem_WR, ALU_WF,
             MuxASel, MuxBSel, MuxCSel, Halted
   );

   modport slave (
      output IROut, ALUOutFlag,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
             ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Write, Mem_CS, Mem_WR, ALU_WF,
             MuxASel, MuxBSel, MuxCSel, Halted
   );
endinterface

// File: rtl/sequencer_control_unit.sv
// Hardwired fetch/decode/execute sequencer (Moore FSM, outputs decoded from state).
// Ports: Clock, Reset (async, active-high, forces CLR);
//        bus (master): IROut/ALUOutFlag in, all datapath controls and Halted out.
// Outputs are a pure decode of the state (plus IROut/flags in E0/E1) so that an
// asserted Reset shows the CLR decode, and drops Mem_CS, in the same cycle.
module sequencer_control_unit (
   input  logic                            Clock,
   input  logic                            Reset,
   sequencer_control_unit_if.master        bus
);
   localparam logic [3:0] OP_BRA = 4'h0;
   localparam logic [3:0] OP_BEQ = 4'h1;
   localparam logic [3:0] OP_BNE = 4'h2;
   localparam logic [3:0] OP_INC = 4'h3;
   localparam logic [3:0] OP_DEC = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_ADD = 4'h6;
   localparam logic [3:0] OP_LD  = 4'h7;
   localparam logic [3:0] OP_ST  = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] FUN_DEC  = 3'b000;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_CLR  = 3'b011;

   localparam logic [2:0] ARF_PC_EN = 3'b011;
   localparam logic [2:0] ARF_AR_EN = 3'b110;

   typedef enum logic [2:0] {
      S_CLR  = 3'd0,
      S_F0   = 3'd1,
      S_F1   = 3'd2,
      S_E0   = 3'd3,
      S_E1   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  opcode;
   logic [1:0]  dst;
   logic [1:0]  src;
   logic        z_flag;
   logic        take_branch;
   logic [3:0]  dst_en;

   assign opcode = bus.IROut[15:12];
   assign dst    = bus.IROut[11:10];
   assign src    = bus.IROut[9:8];
   assign z_flag = bus.ALUOutFlag[3];

   // Active-low register enable: dst 0 (R1) maps to bit 3.
   assign dst_en = ~(4'b1000 >> dst);

   assign take_branch = (opcode == OP_BRA) ||
                        ((opcode == OP_BEQ) && z_flag) ||
                        ((opcode == OP_BNE) && !z_flag);

   // State register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_CLR;
      else       state <= state_next;
   end

   // Next-state and control decode.
   always_comb begin
      state_next      = state;
      bus.RF_OutASel  = 3'b000;
      bus.RF_OutBSel  = 3'b000;
      bus.RF_FunSel   = 3'b000;
      bus.RF_RegSel   = 4'b1111;
      bus.RF_ScrSel   = 4'b1111;
      bus.ALU_FunSel  = 5'b00000;
      bus.ARF_OutCSel = 2'b00;
      bus.ARF_OutDSel = 2'b00;
      bus.ARF_FunSel  = 3'b000;
      bus.ARF_RegSel  = 3'b111;
      bus.IR_LH       = 1'b0;
      bus.IR_Write    = 1'b0;
      bus.Mem_CS      = 1'b1;
      bus.Mem_WR      = 1'b0;
      bus.ALU_WF      = 1'b0;
      bus.MuxASel     = 2'b00;
      bus.MuxBSel     = 2'b00;
      bus.MuxCSel     = 1'b0;
      bus.Halted      = 1'b0;

      case (state)
         S_CLR: begin
            bus.ARF_FunSel = FUN_CLR;
            bus.ARF_RegSel = ARF_PC_EN;
            state_next     = S_F0;
         end
         // Byte fetch from PC; PC steps in both halves so instructions stay 2-byte aligned.
         S_F0, S_F1: begin
            bus.ARF_OutDSel = 2'b00;
            bus.Mem_CS      = 1'b0;
            bus.IR_Write    = 1'b1;
            bus.IR_LH       = (state == S_F1);
            bus.ARF_FunSel  = FUN_INC;
            bus.ARF_RegSel  = ARF_PC_EN;
            state_next      = (state == S_F0) ? S_F1 : S_E0;
         end
         S_E0: begin
            state_next = S_F0;
            case (opcode)
               OP_BRA, OP_BEQ, OP_BNE: begin
                  if (take_branch) begin
                     bus.MuxBSel    = 2'b11;
                     bus.ARF_FunSel = FUN_LOAD;
                     bus.ARF_RegSel = ARF_PC_EN;
                  end
               end
               OP_INC: begin
                  bus.RF_FunSel = FUN_INC;
                  bus.RF_RegSel = dst_en;
               end
               OP_DEC: begin
                  bus.RF_FunSel = FUN_DEC;
                  bus.RF_RegSel = dst_en;
               end
               OP_LDI: begin
                  bus.MuxASel   = 2'b11;
                  bus.RF_FunSel = FUN_LOAD;
                  bus.RF_RegSel = dst_en;
               end
               OP_ADD: begin
                  bus.RF_OutASel = {1'b0, dst};
                  bus.RF_OutBSel = {1'b0, src};
                  bus.ALU_FunSel = 5'b10100;
                  bus.ALU_WF     = 1'b1;
                  bus.MuxASel    = 2'b00;
                  bus.RF_FunSel  = FUN_LOAD;
                  bus.RF_RegSel  = dst_en;
               end
               OP_LD, OP_ST: begin
                  bus.MuxBSel    = 2'b11;
                  bus.ARF_FunSel = FUN_LOAD;
                  bus.ARF_RegSel = ARF_AR_EN;
                  state_next     = S_E1;
               end
               OP_HLT: state_next = S_HALT;
               default: ;
            endcase
         end
         // Memory access through AR, loaded with imm in E0.
         S_E1: begin
            bus.ARF_OutDSel = 2'b10;
            bus.Mem_CS      = 1'b0;
            state_next      = S_F0;
            if (opcode == OP_ST) begin
               bus.Mem_WR     = 1'b1;
               bus.RF_OutASel = {1'b0, dst};
               bus.ALU_FunSel = 5'b10000;
               bus.MuxCSel    = 1'b0;
            end else begin
               bus.Mem_WR    = 1'b0;
               bus.MuxASel   = 2'b10;
               bus.RF_FunSel = FUN_LOAD;
               bus.RF_RegSel = dst_en;
            end
         end
         S_HALT: begin
            bus.Halted = 1'b1;
            state_next = S_HALT;
         end
         default: state_next = S_CLR;
      endcase
   end
endmodule

// File: tb/tb_sequencer_control_unit.sv
// Directed bench: the sequencer drives a small behavioural ALU-system datapath
// (register file, PC/SP/AR, IR, flags, 256-byte memory); programs are checked
// through the resulting architectural state and the control outputs.
module tb_sequencer_control_unit;
   logic Clock;
   logic Reset;

   sequencer_control_unit_if bus ();

   sequencer_control_unit dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Datapath model state.
   logic [15:0] rf [4];
   logic [15:0] pc, sp, ar, ir;
   logic [3:0]  flags;
   logic [7:0]  mem [256];

   logic [15:0] addr, alu_a, alu_b, alu_out, mux_a, mux_b;
   logic [16:0] sum;
   logic [7:0]  mem_out, mux_c;
   logic [3:0]  alu_flags;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [15:0] wr_addr = 16'h0;
   int bad;

   assign bus.IROut      = ir;
   assign bus.ALUOutFlag = flags;

   always @* begin
      case (bus.ARF_OutDSel)
         2'b01:   addr = sp;
         2'b10:   addr = ar;
         default: addr = pc;
      endcase
      mem_out = mem[addr[7:0]];
      alu_a   = rf[bus.RF_OutASel[1:0]];
      alu_b   = rf[bus.RF_OutBSel[1:0]];
      sum     = {1'b0, alu_a} + {1'b0, alu_b};
      if (bus.ALU_FunSel == 5'b10100) begin
         alu_out   = sum[15:0];
         alu_flags = {(sum[15:0] == 16'h0), sum[16], sum[15],
                      (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15])};
      end else begin
         alu_out   = alu_a;
         alu_flags = flags;
      end
      case (bus.MuxASel)
         2'b10:   mux_a = {8'h00, mem_out};
         2'b11:   mux_a = {8'h00, ir[7:0]};
         default: mux_a = alu_out;
      endcase
      mux_b = (bus.MuxBSel == 2'b11) ? {8'h00, ir[7:0]} : alu_out;
      mux_c = alu_out[7:0];
   end

   function automatic logic [15:0] fupd(input logic [15:0] v, input logic [2:0] f,
                                        input logic [15:0] d);
      case (f)
         3'b000:  return v - 16'd1;
         3'b001:  return v + 16'd1;
         3'b010:  return d;
         3'b011:  return 16'h0000;
         default: return v;
      endcase
   endfunction

   always @(posedge Clock) begin
      for (int i = 0; i < 4; i++)
         if (!bus.RF_RegSel[3-i]) rf[i] <= fupd(rf[i], bus.RF_FunSel, mux_a);
      if (!bus.ARF_RegSel[2]) pc <= fupd(pc, bus.ARF_FunSel, mux_b);
      if (!bus.ARF_RegSel[1]) sp <= fupd(sp, bus.ARF_FunSel, mux_b);
      if (!bus.ARF_RegSel[0]) ar <= fupd(ar, bus.ARF_FunSel, mux_b);
      if (bus.IR_Write) begin
         if (bus.IR_LH) ir[15:8] <= mem_out;
         else           ir[7:0]  <= mem_out;
      end
      if (bus.ALU_WF) flags <= alu_flags;
      if (!bus.Mem_CS && bus.Mem_WR) mem[addr[7:0]] <= mux_c;
   end

   // Write-cycle monitor.
   always @(negedge Clock) begin
      if (!bus.Mem_CS && bus.Mem_WR) begin
         wr_count++;
         wr_addr = addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge Clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1;
      ir    = 16'h0000;
      flags = 4'h0;
      sp    = 16'h0000;
      ar    = 16'h0000;
      for (int i = 0; i < 4; i++) rf[i] = 16'h0000;
      clear_mem();
      run(2);

      // Reset held: CLR decode visible.
      check("rst_mem_cs", 32'(bus.Mem_CS), 32'h1);
      check("rst_arf_regsel", 32'(bus.ARF_RegSel), 32'h3);
      check("rst_arf_funsel", 32'(bus.ARF_FunSel), 32'h3);
      check("rst_halted", 32'(bus.Halted), 32'h0);

      // Program: LDI R1,5; LDI R2,3; ADD R1,R2
      mem[0] = 8'h05; mem[1] = 8'h50; mem[2] = 8'h03; mem[3] = 8'h54;
      mem[4] = 8'h00; mem[5] = 8'h61;
      pc = 16'h1234;
      Reset = 1'b0;
      run(1);
      check("clr_pc", 32'(pc), 32'h0);
      check("f0_addr", 32'(addr), 32'h0);
      check("f0_ir_lh", 32'(bus.IR_LH), 32'h0);
      check("f0_ir_write", 32'(bus.IR_Write), 32'h1);
      check("f0_mem_cs", 32'(bus.Mem_CS), 32'h0);
      run(9);
      check("add_r1", 32'(rf[0]), 32'h8);
      check("add_r2", 32'(rf[1]), 32'h3);
      check("add_z", 32'(flags[3]), 32'h0);
      check("add_pc", 32'(pc), 32'h6);

      // Program: LDI R1,0; ADD R1,R1 (Z=1); LDI R1,1; DEC R1; BEQ 0x20
      Reset = 1'b1;
      run(1);
      clear_mem();
      mem[0] = 8'h00; mem[1] = 8'h50; mem[2] = 8'h00; mem[3] = 8'h60;
      mem[4] = 8'h01; mem[5] = 8'h50; mem[6] = 8'h00; mem[7] = 8'h40;
      mem[8] = 8'h20; mem[9] = 8'h10;
      mem[8'h20] = 8'h30; mem[8'h21] = 8'h20;   // BNE 0x30 (not taken)
      mem[8'h22] = 8'h00; mem[8'h23] = 8'h30;   // INC R1
      mem[8'h24] = 8'h10; mem[8'h25] = 8'h00;   // BRA 0x10
      Reset = 1'b0;
      run(1);
      run(15);
      check("beq_pc", 32'(pc), 32'h20);
      check("beq_r1", 32'(rf[0]), 32'h0);
      check("beq_flags", 32'(flags), 32'h8);
      run(3);
      check("bne_nt_pc", 32'(pc), 32'h22);
      run(3);
      check("inc_r1", 32'(rf[0]), 32'h1);
      check("inc_flags", 32'(flags), 32'h8);
      run(3);
      check("bra_pc", 32'(pc), 32'h10);

      // Program: ST R1,0x40; LD R3,0x40 with R1=0x12AB
      Reset = 1'b1;
      run(1);
      clear_mem();
      mem[0] = 8'h40; mem[1] = 8'h80; mem[2] = 8'h40; mem[3] = 8'h78;
      rf[0] = 16'h12AB;
      rf[2] = 16'hFFFF;
      wr_count = 0;
      Reset = 1'b0;
      run(1);
      run(3);
      check("st_e1_wr", 32'(bus.Mem_WR), 32'h1);
      check("st_e1_cs", 32'(bus.Mem_CS), 32'h0);
      check("st_e1_addr", 32'(addr), 32'h40);
      run(5);
      check("st_wr_cycles", 32'(wr_count), 32'h1);
      check("st_wr_addr", 32'(wr_addr), 32'h40);
      check("st_mem", 32'(mem[8'h40]), 32'hAB);
      check("ld_r3", 32'(rf[2]), 32'h00AB);
      check("ldst_pc", 32'(pc), 32'h4);

      // Program: NOP (0xA123); HLT
      Reset = 1'b1;
      run(1);
      clear_mem();
      mem[0] = 8'h23; mem[1] = 8'hA1; mem[2] = 8'h00; mem[3] = 8'hF0;
      Reset = 1'b0;
      run(1);
      run(3);
      check("nop_pc", 32'(pc), 32'h2);
      check("nop_halted", 32'(bus.Halted), 32'h0);
      run(3);
      check("hlt_halted", 32'(bus.Halted), 32'h1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clock);
         if (bus.Halted !== 1'b1 || bus.Mem_CS !== 1'b1) bad++;
      end
      check("hlt_hold", 32'(bad), 32'h0);
      check("hlt_pc", 32'(pc), 32'h4);
      #1 Reset = 1'b1;
      #1;
      check("hlt_rst_halted", 32'(bus.Halted), 32'h0);
      check("hlt_rst_regsel", 32'(bus.ARF_RegSel), 32'h3);
      @(negedge Clock);
      Reset = 1'b0;
      run(1);
      check("hlt_rst_pc", 32'(pc), 32'h0);
      check("hlt_rst_fetch", 32'(bus.IR_Write), 32'h1);

      // Reset during E1 of ST
      Reset = 1'b1;
      run(1);
      clear_mem();
      mem[0] = 8'h40; mem[1] = 8'h80;
      rf[0] = 16'h5555;
      Reset = 1'b0;
      run(1);
      run(3);
      check("e1_wr", 32'(bus.Mem_WR), 32'h1);
      check("e1_pc", 32'(pc), 32'h2);
      #1 Reset = 1'b1;
      #1;
      check("e1_rst_cs", 32'(bus.Mem_CS), 32'h1);
      check("e1_rst_wr", 32'(bus.Mem_WR), 32'h0);
      @(negedge Clock);
      Reset = 1'b0;
      run(1);
      check("e1_rst_pc", 32'(pc), 32'h0);
      check("e1_rst_addr", 32'(addr), 32'h0);
      check("e1_rst_ir_lh", 32'(bus.IR_LH), 32'h0);
      check("e1_rst_fetch_cs", 32'(bus.Mem_CS), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
